// File: rtl/pcie_datalink_pkg.sv
// Shared data-link layer definitions: arbiter FSM encoding, DLLP source
// port indices and the default aging threshold.
package pcie_datalink_pkg;

    // Arbiter ownership state.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Fixed DLLP source assignment on the TX arbiter (lower index = higher priority).
    localparam int unsigned DllpPortAckNak   = 0;
    localparam int unsigned DllpPortFcInit   = 1;
    localparam int unsigned DllpPortUpdateFc = 2;

    // Cycles a waiting requester accumulates before it is promoted.
    localparam int unsigned DllpStarveLimitDefault = 64;

endpackage : pcie_datalink_pkg

// File: rtl/pcie_prio_age_picker.sv
// Combinational winner picker: fixed priority (lowest index wins) with an
// aging override where any starved requester beats every non-starved one.
// Ports:
//   req_valid   - per-port request
//   req_starved - per-port aging flag (only honoured together with req_valid)
//   winner_c    - one-hot winner, all-zero when nothing requests
module pcie_prio_age_picker #(
    parameter int unsigned NUM_PORTS = 3
) (
    input  logic [NUM_PORTS-1:0] req_valid,
    input  logic [NUM_PORTS-1:0] req_starved,
    output logic [NUM_PORTS-1:0] winner_c
);

    logic [NUM_PORTS-1:0] aged;
    logic [NUM_PORTS-1:0] cand;

    // Restrict to the starved set when it is non-empty, then isolate the lowest set bit.
    always_comb begin
        aged     = req_valid & req_starved;
        cand     = (|aged) ? aged : req_valid;
        winner_c = cand & (~cand + NUM_PORTS'(1));
    end

endmodule : pcie_prio_age_picker

// File: rtl/pcie_dllp_tx_arbiter.sv
// Packet-granular arbiter sharing the DLLP transmit AXI-Stream between
// NUM_PORTS DLLP sources (Ack/Nak, FC init, UpdateFC). A granted port owns
// the output until its tlast beat is accepted, so payload and CRC beats of a
// DLLP never interleave with another source. Per-port wait counters promote
// a source that has waited STARVE_LIMIT cycles above all non-starved ones.
// Ports:
//   clk_i, rst_ni        - clock, synchronous active-low reset
//   s_axis_*             - per-port source streams, port i in slice i
//   m_axis_*             - arbitrated stream towards DLLP framing
//   grant_o              - one-hot current owner, zero when idle
//   starved_o            - per-port wait counter at STARVE_LIMIT
module pcie_dllp_tx_arbiter
    import pcie_datalink_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH   = 3,
    parameter int unsigned NUM_PORTS    = 3,
    parameter int unsigned STARVE_LIMIT = DllpStarveLimitDefault
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]             s_axis_tlast,
    input  logic [NUM_PORTS*USER_WIDTH-1:0]  s_axis_tuser,
    output logic [NUM_PORTS-1:0]             s_axis_tready,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tvalid,
    output logic                             m_axis_tlast,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,
    input  logic                             m_axis_tready,
    output logic [NUM_PORTS-1:0]             grant_o,
    output logic [NUM_PORTS-1:0]             starved_o
);

    localparam int unsigned CntWidth = $clog2(STARVE_LIMIT + 1);

    // Elaboration-time guard on the supported configuration range.
    if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_ports
        $error("pcie_dllp_tx_arbiter: NUM_PORTS must be 2..8");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("pcie_dllp_tx_arbiter: STARVE_LIMIT must be >= 1");
    end

    arb_state_e           state_q;
    arb_state_e           state_d;
    logic [NUM_PORTS-1:0] grant_q;
    logic [NUM_PORTS-1:0] grant_d;
    logic [NUM_PORTS-1:0] winner_c;
    logic [NUM_PORTS-1:0] win_load_c;
    logic [NUM_PORTS-1:0] starved_c;
    logic                 pkt_end_c;

    // Winner selection over the live requests and the aging flags.
    pcie_prio_age_picker #(
        .NUM_PORTS (NUM_PORTS)
    ) u_picker (
        .req_valid   (s_axis_tvalid),
        .req_starved (starved_c),
        .winner_c    (winner_c)
    );

    // A winner is only registered from idle; this is also the counter-clear strobe.
    assign win_load_c = (state_q == ST_IDLE) ? winner_c : '0;

    // Owner's tlast beat accepted downstream.
    assign pkt_end_c = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Next-state logic: lock on any request, release after the tlast handshake.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (|s_axis_tvalid) begin
                    state_d = ST_LOCKED;
                    grant_d = winner_c;
                end
            end
            ST_LOCKED: begin
                if (pkt_end_c) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Pass-through mux from the owner; everything is quiet while idle.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;
        s_axis_tready = '0;
        if (state_q == ST_LOCKED) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant_q[i]) begin
                    m_axis_tdata  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                    m_axis_tkeep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                    m_axis_tvalid = s_axis_tvalid[i];
                    m_axis_tlast  = s_axis_tlast[i];
                    m_axis_tuser  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
                end
            end
            s_axis_tready = grant_q & {NUM_PORTS{m_axis_tready}};
        end
    end

    // Per-port wait counters: count while requesting without ownership,
    // saturate at the limit, hold across tvalid gaps, clear on being picked.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_age
        logic [CntWidth-1:0] cnt_q;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else if (win_load_c[i]) begin
                cnt_q <= '0;
            end else if (s_axis_tvalid[i] && !grant_q[i] &&
                         (cnt_q != CntWidth'(STARVE_LIMIT))) begin
                cnt_q <= cnt_q + CntWidth'(1);
            end
        end

        assign starved_c[i] = (cnt_q == CntWidth'(STARVE_LIMIT));
    end

    assign grant_o   = grant_q;
    assign starved_o = starved_c;

endmodule : pcie_dllp_tx_arbiter

// File: tb/tb_pcie_dllp_tx_arbiter.sv
// Self-checking bench for pcie_dllp_tx_arbiter (STARVE_LIMIT=4).
// Inputs change 1 time unit after the rising edge, outputs are sampled on
// the falling edge. Expected beats go into a scoreboard queue in the order
// the arbiter must emit them; every accepted output beat is popped and compared.
module tb_pcie_dllp_tx_arbiter;
    import pcie_datalink_pkg::*;

    localparam int unsigned NP = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned KW = 4;
    localparam int unsigned UW = 3;
    localparam int unsigned SL = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            port;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP*KW-1:0]  s_tkeep;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tlast;
    logic [NP*UW-1:0]  s_tuser;
    logic [NP-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tvalid;
    logic              m_tlast;
    logic [UW-1:0]     m_tuser;
    logic              m_tready;
    logic [NP-1:0]     grant;
    logic [NP-1:0]     starved;

    beat_t         src_q [NP][$];
    beat_t         sb_q[$];
    logic [NP-1:0] gap_ctl;
    logic          rdy_ctl;
    logic          rst_ctl;
    logic [NP-1:0] took;
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    pcie_dllp_tx_arbiter #(
        .DATA_WIDTH   (DW),
        .KEEP_WIDTH   (KW),
        .USER_WIDTH   (UW),
        .NUM_PORTS    (NP),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .m_axis_tready (m_tready),
        .grant_o       (grant),
        .starved_o     (starved)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [UW-1:0] user_of(input int p);
        return UW'(p + 1);
    endfunction

    task automatic push_src(input int p, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        beat_t b;
        b.port = p;
        b.data = d0; b.last = 1'b0; src_q[p].push_back(b);
        b.data = d1; b.last = 1'b1; src_q[p].push_back(b);
    endtask

    task automatic expect_pkt(input int p, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        beat_t b;
        b.port = p;
        b.data = d0; b.last = 1'b0; sb_q.push_back(b);
        b.data = d1; b.last = 1'b1; sb_q.push_back(b);
    endtask

    // One clock: drive inputs after the rising edge, then sample and score on the falling edge.
    task automatic step();
        beat_t e;
        logic [31:0] gexp;
        @(posedge clk);
        #1;
        rst_n    = rst_ctl;
        m_tready = rdy_ctl;
        for (int p = 0; p < NP; p++) begin
            if (took[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
            if (src_q[p].size() > 0 && !gap_ctl[p]) begin
                s_tvalid[p]            = 1'b1;
                s_tdata[p*DW +: DW]    = src_q[p][0].data;
                s_tlast[p]             = src_q[p][0].last;
                s_tkeep[p*KW +: KW]    = src_q[p][0].last ? 4'h3 : 4'hF;
                s_tuser[p*UW +: UW]    = user_of(p);
            end else begin
                s_tvalid[p] = 1'b0;
            end
        end
        @(negedge clk);
        took = s_tvalid & s_tready;
        if (m_tvalid && m_tready) begin
            if (sb_q.size() == 0) begin
                check("mon_unexpected_beat", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                gexp = 32'd1 << e.port;
                check("mon_data",  m_tdata, e.data);
                check("mon_last",  32'(m_tlast), 32'(e.last));
                check("mon_keep",  32'(m_tkeep), e.last ? 32'h3 : 32'hF);
                check("mon_user",  32'(m_tuser), 32'(user_of(e.port)));
                check("mon_grant", 32'(grant), gexp);
            end
        end
    endtask

    task automatic drain(input string tag, input int budget);
        for (int k = 0; k < budget && sb_q.size() > 0; k++) step();
        check(tag, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_grant"},   32'(grant),    32'd0);
        check({tag, "_mvalid"},  32'(m_tvalid), 32'd0);
        check({tag, "_sready"},  32'(s_tready), 32'd0);
        check({tag, "_starved"}, 32'(starved),  32'd0);
        check({tag, "_mdata"},   m_tdata,       32'd0);
        check({tag, "_mlast"},   32'(m_tlast),  32'd0);
        check({tag, "_mkeep"},   32'(m_tkeep),  32'd0);
        check({tag, "_muser"},   32'(m_tuser),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        m_tready = 1'b0;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = '0;
        s_tuser  = '0;
        took     = '0;
        gap_ctl  = '0;
        rdy_ctl  = 1'b1;
        rst_ctl  = 1'b0;

        // Reset state.
        repeat (3) step();
        check_quiet("reset");
        rst_ctl = 1'b1;
        repeat (2) step();
        check_quiet("post_reset");

        // Single FC-init DLLP.
        push_src(DllpPortFcInit, 32'hA1B2C3D4, 32'h0000BEEF);
        expect_pkt(DllpPortFcInit, 32'hA1B2C3D4, 32'h0000BEEF);
        step();
        check("single_grant_wait", 32'(grant), 32'd0);
        step();
        check("single_grant", 32'(grant), 32'b010);
        check("single_mvalid", 32'(m_tvalid), 32'd1);
        step();
        check("single_beat2_grant", 32'(grant), 32'b010);
        step();
        check("single_idle_grant", 32'(grant), 32'd0);
        check("single_idle_mvalid", 32'(m_tvalid), 32'd0);
        check("single_drained", 32'(sb_q.size()), 32'd0);

        // Ports 0 and 2 together: port 0 first, port 2 two cycles after port 0's tlast.
        push_src(DllpPortAckNak, 32'h00000A01, 32'h00000A02);
        push_src(DllpPortUpdateFc, 32'h00000C01, 32'h00000C02);
        expect_pkt(DllpPortAckNak, 32'h00000A01, 32'h00000A02);
        expect_pkt(DllpPortUpdateFc, 32'h00000C01, 32'h00000C02);
        step();
        step();
        check("pair_grant_p0", 32'(grant), 32'b001);
        check("pair_sready", 32'(s_tready), 32'b001);
        step();
        check("pair_p0_last", 32'(m_tlast), 32'd1);
        step();
        check("pair_idle_gap", 32'(grant), 32'd0);
        check("pair_not_starved_at_3", 32'(starved), 32'd0);
        step();
        check("pair_grant_p2", 32'(grant), 32'b100);
        drain("pair_drain", 20);
        step();
        check("pair_end_idle", 32'(grant), 32'd0);

        // Aging: port 0 streams, port 2 is promoted after 4 waiting cycles.
        push_src(DllpPortAckNak, 32'h0A000001, 32'h0A000002);
        push_src(DllpPortAckNak, 32'h0B000001, 32'h0B000002);
        push_src(DllpPortAckNak, 32'h0C000001, 32'h0C000002);
        push_src(DllpPortUpdateFc, 32'h2F000001, 32'h2F000002);
        expect_pkt(DllpPortAckNak, 32'h0A000001, 32'h0A000002);
        expect_pkt(DllpPortAckNak, 32'h0B000001, 32'h0B000002);
        expect_pkt(DllpPortUpdateFc, 32'h2F000001, 32'h2F000002);
        expect_pkt(DllpPortAckNak, 32'h0C000001, 32'h0C000002);
        step();
        step();
        check("age_grant0_a", 32'(grant), 32'b001);
        check("age_starved_a", 32'(starved), 32'b000);
        step();
        step();
        check("age_idle1_grant", 32'(grant), 32'd0);
        check("age_idle1_starved", 32'(starved), 32'b000);
        step();
        check("age_grant0_b", 32'(grant), 32'b001);
        check("age_starved_rise", 32'(starved), 32'b100);
        step();
        step();
        check("age_idle2_starved", 32'(starved), 32'b100);
        step();
        check("age_grant2", 32'(grant), 32'b100);
        check("age_cnt_cleared", 32'(starved), 32'b000);
        drain("age_drain", 40);
        step();
        check("age_end_idle", 32'(grant), 32'd0);
        check("age_end_starved", 32'(starved), 32'd0);

        // Downstream stall between beats with port 0 requesting meanwhile.
        push_src(DllpPortFcInit, 32'h11110001, 32'h11110002);
        expect_pkt(DllpPortFcInit, 32'h11110001, 32'h11110002);
        expect_pkt(DllpPortAckNak, 32'h0D000001, 32'h0D000002);
        step();
        step();
        rdy_ctl = 1'b0;
        push_src(DllpPortAckNak, 32'h0D000001, 32'h0D000002);
        for (int k = 0; k < 10; k++) begin
            step();
            check("stall_grant", 32'(grant), 32'b010);
            check("stall_sready", 32'(s_tready), 32'b000);
            check("stall_mdata", m_tdata, 32'h11110002);
        end
        rdy_ctl = 1'b1;
        drain("stall_drain", 20);
        step();
        check("stall_end_idle", 32'(grant), 32'd0);

        // Reset in the middle of a packet, then a clean resend.
        push_src(DllpPortFcInit, 32'hA1B2C3D4, 32'h0000BEEF);
        expect_pkt(DllpPortFcInit, 32'hA1B2C3D4, 32'h0000BEEF);
        step();
        step();
        check("rst_pre_grant", 32'(grant), 32'b010);
        rst_ctl = 1'b0;
        rdy_ctl = 1'b0;
        step();
        step();
        check_quiet("rst_mid");
        rst_ctl = 1'b1;
        rdy_ctl = 1'b1;
        src_q[DllpPortFcInit].delete();
        sb_q.delete();
        push_src(DllpPortFcInit, 32'hA1B2C3D4, 32'h0000BEEF);
        expect_pkt(DllpPortFcInit, 32'hA1B2C3D4, 32'h0000BEEF);
        step();
        check("rst_resend_wait", 32'(grant), 32'd0);
        step();
        check("rst_resend_grant", 32'(grant), 32'b010);
        drain("rst_drain", 20);
        step();
        check("rst_end_idle", 32'(grant), 32'd0);

        // Owner tvalid gap of three cycles between beats.
        push_src(DllpPortFcInit, 32'hC0DE0001, 32'hC0DE0002);
        expect_pkt(DllpPortFcInit, 32'hC0DE0001, 32'hC0DE0002);
        step();
        step();
        gap_ctl[DllpPortFcInit] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("gap_mvalid", 32'(m_tvalid), 32'd0);
            check("gap_grant", 32'(grant), 32'b010);
        end
        gap_ctl[DllpPortFcInit] = 1'b0;
        step();
        check("gap_resume_last", 32'(m_tlast), 32'd1);
        drain("gap_drain", 10);
        step();
        check("gap_end_idle", 32'(grant), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pcie_dllp_tx_arbiter
